mem_wb_pipe: RTL and testbench

Parametrised MEM→WB pipeline register for the 5-stage MIPS core. It selects the GPR write-back value from six sources and performs sub-word load extraction and sign/zero extension. It supports stall (hold) and flush (bubble) from the pipeline controller and suppresses writes to $0. It also keeps a retired-instruction counter for debug/perf. It sits between the MEM stage (DMEM read data, EXE_MEM_reg outputs) and the GPR file write port.

---
 rtl/mem_wb_pipe_if.sv | 39 +++
 rtl/mem_wb_pipe.sv | 81 ++++++++
 tb/tb_mem_wb_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_if.sv
// MEM->WB bus: MEM-stage results going in, registered WB-stage write-back fields coming out.
interface mem_wb_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              mem_valid;
    logic [XLEN-1:0]   mem_pc_in;
    logic [XLEN-1:0]   mem_dmem_rdata_in;
    logic [XLEN-1:0]   mem_alu_result_in;
    logic [XLEN-1:0]   mem_hi_in;
    logic [XLEN-1:0]   mem_lo_in;
    logic [XLEN-1:0]   mem_cp0_rdata_in;
    logic [2:0]        mem_load_type_in;
    logic              mem_GPR_we_in;
    logic [REG_AW-1:0] mem_GPR_waddr_in;
    logic [2:0]        mem_GPR_wdata_select_in;

    logic              wb_valid;
    logic [XLEN-1:0]   wb_pc;
    logic              wb_GPR_we;
    logic [REG_AW-1:0] wb_GPR_waddr;
    logic [XLEN-1:0]   wb_GPR_wdata;
    logic [CNT_W-1:0]  wb_retire_count;

    modport master (
        output mem_valid, mem_pc_in, mem_dmem_rdata_in, mem_alu_result_in,
               mem_hi_in, mem_lo_in, mem_cp0_rdata_in, mem_load_type_in,
               mem_GPR_we_in, mem_GPR_waddr_in, mem_GPR_wdata_select_in,
        input  wb_valid, wb_pc, wb_GPR_we, wb_GPR_waddr, wb_GPR_wdata, wb_retire_count
    );

    modport slave (
        input  mem_valid, mem_pc_in, mem_dmem_rdata_in, mem_alu_result_in,
               mem_hi_in, mem_lo_in, mem_cp0_rdata_in, mem_load_type_in,
               mem_GPR_we_in, mem_GPR_waddr_in, mem_GPR_wdata_select_in,
        output wb_valid, wb_pc, wb_GPR_we, wb_GPR_waddr, wb_GPR_wdata, wb_retire_count
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: load extraction, write-back source select, stall/flush,
// $0 write suppression and a retired-instruction counter.
module mem_wb_pipe #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int LINK_OFFSET = 8,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    mem_wb_pipe_if.slave  bus
);

    logic [1:0]      off;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] link_data;
    logic [XLEN-1:0] wdata_next;
    logic            we_next;

    assign off = bus.mem_alu_result_in[1:0];

    // Halfword select uses only off[1]; misaligned halfwords are trapped before MEM.
    always_comb begin
        load_byte = bus.mem_dmem_rdata_in[{off, 3'b000} +: 8];
        load_half = bus.mem_dmem_rdata_in[{off[1], 4'b0000} +: 16];
        case (bus.mem_load_type_in)
            3'd1:    load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'd2:    load_data = {{(XLEN-8){1'b0}}, load_byte};
            3'd3:    load_data = {{(XLEN-16){load_half[15]}}, load_half};
            3'd4:    load_data = {{(XLEN-16){1'b0}}, load_half};
            default: load_data = bus.mem_dmem_rdata_in;
        endcase
    end

    assign link_data = bus.mem_pc_in + XLEN'(LINK_OFFSET);

    always_comb begin
        case (bus.mem_GPR_wdata_select_in)
            3'd0:    wdata_next = load_data;
            3'd1:    wdata_next = bus.mem_alu_result_in;
            3'd2:    wdata_next = link_data;
            3'd3:    wdata_next = bus.mem_hi_in;
            3'd4:    wdata_next = bus.mem_lo_in;
            3'd5:    wdata_next = bus.mem_cp0_rdata_in;
            default: wdata_next = '1;
        endcase
    end

    assign we_next = bus.mem_valid & bus.mem_GPR_we_in & (bus.mem_GPR_waddr_in != '0);

    // Priority reset > flush > stall > advance; the counter only moves on a real advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_valid        <= 1'b0;
            bus.wb_pc           <= '0;
            bus.wb_GPR_we       <= 1'b0;
            bus.wb_GPR_waddr    <= '0;
            bus.wb_GPR_wdata    <= '0;
            bus.wb_retire_count <= '0;
        end else if (flush) begin
            bus.wb_valid        <= 1'b0;
            bus.wb_pc           <= '0;
            bus.wb_GPR_we       <= 1'b0;
            bus.wb_GPR_waddr    <= '0;
            bus.wb_GPR_wdata    <= '0;
        end else if (!stall) begin
            bus.wb_valid        <= bus.mem_valid;
            bus.wb_pc           <= bus.mem_pc_in;
            bus.wb_GPR_we       <= we_next;
            bus.wb_GPR_waddr    <= bus.mem_GPR_waddr_in;
            bus.wb_GPR_wdata    <= wdata_next;
            if (bus.mem_valid)
                bus.wb_retire_count <= bus.wb_retire_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe (counter width 4 so the wrap is reachable).
module tb_mem_wb_pipe;

    logic clk = 1'b0;
    logic reset, stall, flush;
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] exp_cnt;

    always #5 clk = ~clk;

    mem_wb_pipe_if #(.XLEN(32), .REG_AW(5), .CNT_W(4)) bus ();

    mem_wb_pipe #(.XLEN(32), .REG_AW(5), .LINK_OFFSET(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    task automatic setMem(input logic v, input logic [31:0] pc, input logic [31:0] rdata,
                          input logic [31:0] alu, input logic [2:0] lt, input logic we,
                          input logic [4:0] wa, input logic [2:0] sel);
        bus.mem_valid               = v;
        bus.mem_pc_in               = pc;
        bus.mem_dmem_rdata_in       = rdata;
        bus.mem_alu_result_in       = alu;
        bus.mem_load_type_in        = lt;
        bus.mem_GPR_we_in           = we;
        bus.mem_GPR_waddr_in        = wa;
        bus.mem_GPR_wdata_select_in = sel;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [31:0] pc, input logic [3:0] cnt);
        checkVal({tag, ".valid"}, {31'd0, bus.wb_valid}, {31'd0, v});
        checkVal({tag, ".we"},    {31'd0, bus.wb_GPR_we}, {31'd0, we});
        checkVal({tag, ".waddr"}, {27'd0, bus.wb_GPR_waddr}, {27'd0, wa});
        checkVal({tag, ".wdata"}, bus.wb_GPR_wdata, wd);
        checkVal({tag, ".pc"},    bus.wb_pc, pc);
        checkVal({tag, ".count"}, {28'd0, bus.wb_retire_count}, {28'd0, cnt});
    endtask

    // Runs one valid load from the fixed test word and checks the extracted value.
    task automatic loadStep(input string tag, input logic [2:0] lt, input logic [1:0] off,
                            input logic [31:0] exp);
        setMem(1'b1, 32'h0000_0300, 32'h80FF_7F01, {30'd0, off}, lt, 1'b1, 5'd3, 3'd0);
        applyStimulus();
        exp_cnt++;
        checkOutput(tag, 1'b1, 1'b1, 5'd3, exp, 32'h0000_0300, exp_cnt);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        bus.mem_hi_in        = 32'hAAAA_5555;
        bus.mem_lo_in        = 32'h1357_9BDF;
        bus.mem_cp0_rdata_in = 32'hDEAD_BEEF;
        exp_cnt = 4'd0;

        setMem(1'b1, 32'h0000_0040, 32'h0, 32'h1111_1111, 3'd0, 1'b1, 5'd8, 3'd1);
        applyStimulus();
        applyStimulus();
        checkOutput("reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 4'd0);

        reset = 1'b0;
        setMem(1'b1, 32'h0000_0100, 32'h0, 32'h1234_5678, 3'd0, 1'b1, 5'd8, 3'd1);
        applyStimulus();
        exp_cnt++;
        checkOutput("first_alu", 1'b1, 1'b1, 5'd8, 32'h1234_5678, 32'h0000_0100, exp_cnt);

        loadStep("lb0",  3'd1, 2'd0, 32'h0000_0001);
        loadStep("lb1",  3'd1, 2'd1, 32'h0000_007F);
        loadStep("lb2",  3'd1, 2'd2, 32'hFFFF_FFFF);
        loadStep("lb3",  3'd1, 2'd3, 32'hFFFF_FF80);
        loadStep("lbu3", 3'd2, 2'd3, 32'h0000_0080);
        loadStep("lh2",  3'd3, 2'd2, 32'hFFFF_80FF);
        loadStep("lh3",  3'd3, 2'd3, 32'hFFFF_80FF);
        loadStep("lhu0", 3'd4, 2'd0, 32'h0000_7F01);
        loadStep("lw",   3'd0, 2'd1, 32'h80FF_7F01);
        loadStep("lt7",  3'd7, 2'd2, 32'h80FF_7F01);

        setMem(1'b1, 32'h0040_0010, 32'h0, 32'h0, 3'd0, 1'b1, 5'd31, 3'd2);
        applyStimulus();
        exp_cnt++;
        checkOutput("link", 1'b1, 1'b1, 5'd31, 32'h0040_0018, 32'h0040_0010, exp_cnt);

        setMem(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 3'd0, 1'b1, 5'd31, 3'd2);
        applyStimulus();
        exp_cnt++;
        checkOutput("link_wrap", 1'b1, 1'b1, 5'd31, 32'h0000_0004, 32'hFFFF_FFFC, exp_cnt);

        setMem(1'b1, 32'h0000_0500, 32'h0, 32'h0, 3'd0, 1'b1, 5'd4, 3'd3);
        applyStimulus();
        exp_cnt++;
        checkOutput("hi", 1'b1, 1'b1, 5'd4, 32'hAAAA_5555, 32'h0000_0500, exp_cnt);

        bus.mem_GPR_wdata_select_in = 3'd4;
        applyStimulus();
        exp_cnt++;
        checkOutput("lo", 1'b1, 1'b1, 5'd4, 32'h1357_9BDF, 32'h0000_0500, exp_cnt);

        bus.mem_GPR_wdata_select_in = 3'd5;
        applyStimulus();
        exp_cnt++;
        checkOutput("cp0", 1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 32'h0000_0500, exp_cnt);

        bus.mem_GPR_wdata_select_in = 3'd7;
        applyStimulus();
        exp_cnt++;
        checkOutput("sel7", 1'b1, 1'b1, 5'd4, 32'hFFFF_FFFF, 32'h0000_0500, exp_cnt);

        bus.mem_GPR_wdata_select_in = 3'd6;
        applyStimulus();
        exp_cnt++;
        checkOutput("sel6", 1'b1, 1'b1, 5'd4, 32'hFFFF_FFFF, 32'h0000_0500, exp_cnt);

        setMem(1'b1, 32'h0000_0600, 32'h0, 32'h0000_00AA, 3'd0, 1'b1, 5'd0, 3'd1);
        applyStimulus();
        exp_cnt++;
        checkOutput("reg0", 1'b1, 1'b0, 5'd0, 32'h0000_00AA, 32'h0000_0600, exp_cnt);

        setMem(1'b1, 32'h0000_0604, 32'h0, 32'h0000_00BB, 3'd0, 1'b0, 5'd5, 3'd1);
        applyStimulus();
        exp_cnt++;
        checkOutput("we_off", 1'b1, 1'b0, 5'd5, 32'h0000_00BB, 32'h0000_0604, exp_cnt);

        setMem(1'b0, 32'h0000_0608, 32'h0, 32'h0000_00CC, 3'd0, 1'b1, 5'd6, 3'd1);
        applyStimulus();
        checkOutput("bubble_in", 1'b0, 1'b0, 5'd6, 32'h0000_00CC, 32'h0000_0608, exp_cnt);

        setMem(1'b1, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 3'd0, 1'b1, 5'd9, 3'd1);
        applyStimulus();
        exp_cnt++;
        checkOutput("instr_a", 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 32'h0000_0200, exp_cnt);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setMem(1'b1, 32'h0000_0204 + 32'(4*i), 32'h0, 32'h0BAD_0000 + 32'(i), 3'd0,
                   1'b1, 5'd10 + 5'(i), 3'd1);
            applyStimulus();
            checkOutput("stall_hold", 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 32'h0000_0200, exp_cnt);
        end

        flush = 1'b1;
        applyStimulus();
        checkOutput("stall_flush", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, exp_cnt);

        stall = 1'b0;
        setMem(1'b1, 32'h0000_0700, 32'h0, 32'h5555_AAAA, 3'd0, 1'b1, 5'd12, 3'd1);
        applyStimulus();
        checkOutput("flush_only", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, exp_cnt);

        flush = 1'b0;
        stall = 1'b1;
        reset = 1'b1;
        applyStimulus();
        exp_cnt = 4'd0;
        checkOutput("reset_in_stall", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, exp_cnt);

        reset = 1'b0;
        stall = 1'b0;
        applyStimulus();
        exp_cnt++;
        checkOutput("after_reset", 1'b1, 1'b1, 5'd12, 32'h5555_AAAA, 32'h0000_0700, exp_cnt);

        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            setMem(1'b1, 32'h0000_1000 + 32'(4*i), 32'h0, 32'(i), 3'd0, 1'b1, 5'd7, 3'd1);
            applyStimulus();
        end
        checkOutput("wrap17", 1'b1, 1'b1, 5'd7, 32'h0000_0010, 32'h0000_1040, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
